hit_judge: RTL

Chart-driven key judgement stage sitting between the `DFJK` key sampling and the universal frame timer, downstream of the SDRAM arbiter. It fetches 128-bit note-chart words from SDRAM through its own arbiter client port. It unpacks the words into per-lane note queues and, once per `new_frame`, grades each lane's head note as PERFECT, GOOD or MISS against `un_time`. Results feed the sprite/score renderer.

---
 rtl/rhythm_pkg.sv | 38 +++
 rtl/lane_fifo.sv | 63 ++++++
 rtl/hit_judge.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/rhythm_pkg.sv
// Shared types and constants for the chart-driven hit judgement pipeline.
package rhythm_pkg;

  localparam int unsigned NOTE_W    = 14;
  localparam int unsigned LANE_W    = 2;
  localparam int unsigned ENTRY_W   = 16;
  localparam int unsigned WORD_W    = 128;
  localparam int unsigned ENTRIES   = 8;
  localparam int unsigned NUM_LANES = 4;
  localparam int unsigned TIME_W    = 16;
  localparam int unsigned DELTA_W   = 17;
  localparam int unsigned SCORE_W   = 20;
  localparam int unsigned COMBO_W   = 10;

  localparam int unsigned PERFECT_WIN = 2;
  localparam int unsigned GOOD_WIN    = 5;
  localparam int unsigned PTS_PERFECT = 300;
  localparam int unsigned PTS_GOOD    = 100;

  localparam logic [ENTRY_W-1:0] SENTINEL = 16'hFFFF;

  typedef enum logic [1:0] {
    GRADE_NONE    = 2'd0,
    GRADE_PERFECT = 2'd1,
    GRADE_GOOD    = 2'd2,
    GRADE_MISS    = 2'd3
  } grade_t;

  typedef struct packed {
    logic [LANE_W-1:0] lane;
    logic [NOTE_W-1:0] ntime;
  } note_t;

  function automatic logic [DELTA_W-1:0] abs_delta(input logic signed [DELTA_W-1:0] d);
    return d[DELTA_W-1] ? DELTA_W'(-d) : DELTA_W'(d);
  endfunction

endpackage

// File: rtl/lane_fifo.sv
// Per-lane note-time queue; push is dropped when full, pop when empty.
module lane_fifo
  import rhythm_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_i,
  input  logic              push_i,
  input  logic [NOTE_W-1:0] data_i,
  input  logic              pop_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [NOTE_W-1:0] head_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [NOTE_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_q, rd_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              do_push, do_pop;

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_q];

  always_comb begin
    cnt_d = cnt_q;
    if (do_push && !do_pop) cnt_d = cnt_q + CNT_W'(1);
    else if (do_pop && !do_push) cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      full_o  <= 1'b0;
      empty_o <= 1'b1;
    end else if (clr_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      full_o  <= 1'b0;
      empty_o <= 1'b1;
    end else begin
      if (do_push) wr_q <= wr_q + PTR_W'(1);
      if (do_pop)  rd_q <= rd_q + PTR_W'(1);
      cnt_q   <= cnt_d;
      full_o  <= (cnt_d == CNT_W'(DEPTH));
      empty_o <= (cnt_d == '0);
    end
  end

  // Storage carries no reset; validity is tracked by the counters.
  always_ff @(posedge clk) begin
    if (do_push && !clr_i) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/hit_judge.sv
// Fetches chart words from SDRAM, distributes notes into lane queues and
// grades each lane's head note once per frame against the key presses.
module hit_judge
  import rhythm_pkg::*;
#(
  parameter logic [21:0] CHART_BASE = 22'h30_0000,
  parameter int unsigned MAX_WORDS  = 4096,
  parameter int unsigned LANE_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 new_frame,
  input  logic [NUM_LANES-1:0] DFJK,
  input  logic [TIME_W-1:0]    un_time,
  output logic                 sdram_rd,
  output logic [21:0]          sdram_addr,
  input  logic                 sdram_wait,
  input  logic                 sdram_ac,
  input  logic [WORD_W-1:0]    sdram_data,
  output logic                 judge_valid,
  output logic [1:0]           judge_lane,
  output logic [1:0]           judge_grade,
  output logic [SCORE_W-1:0]   score,
  output logic [COMBO_W-1:0]   combo,
  output logic                 chart_done,
  output logic                 busy
);

  localparam int unsigned WCNT_W = $clog2(MAX_WORDS + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DIST, S_END} fetch_t;

  fetch_t             state_q;
  logic               rd_q, busy_q, done_q, discard_q;
  logic [21:0]        addr_q;
  logic [WORD_W-1:0]  word_q;
  logic [2:0]         idx_q;
  logic [WCNT_W-1:0]  wcnt_q;

  logic                 sweep_q, valid_q;
  logic [LANE_W-1:0]    jlane_q, lane_out_q;
  logic [NUM_LANES-1:0] press_q, dfjk_prev_q;
  logic [TIME_W-1:0]    time_q;
  grade_t               grade_q, grade_c;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [COMBO_W-1:0]   combo_q, combo_d;

  logic [NUM_LANES-1:0] full_v, empty_v, push_v, pop_v;
  logic [NOTE_W-1:0]    head_v [NUM_LANES];
  note_t                entry_c;
  logic                 is_sent_c, push_ok_c;
  logic signed [DELTA_W-1:0] delta_c;
  logic [DELTA_W-1:0]   mag_c;
  logic [SCORE_W:0]     sum_c;

  assign sdram_rd    = rd_q;
  assign sdram_addr  = addr_q;
  assign busy        = busy_q;
  assign chart_done  = done_q;
  assign judge_valid = valid_q;
  assign judge_lane  = lane_out_q;
  assign judge_grade = grade_q;
  assign score       = score_q;
  assign combo       = combo_q;

  assign entry_c   = word_q[{idx_q, 4'b0000} +: ENTRY_W];
  assign is_sent_c = (word_q[{idx_q, 4'b0000} +: ENTRY_W] == SENTINEL);
  assign push_ok_c = (state_q == S_DIST) && !start && !is_sent_c && !full_v[entry_c.lane];
  assign push_v    = push_ok_c ? (NUM_LANES'(1) << entry_c.lane) : '0;
  assign pop_v     = (grade_c != GRADE_NONE) ? (NUM_LANES'(1) << jlane_q) : '0;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    lane_fifo #(.DEPTH(LANE_DEPTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .clr_i   (start),
      .push_i  (push_v[g]),
      .data_i  (entry_c.ntime),
      .pop_i   (pop_v[g]),
      .full_o  (full_v[g]),
      .empty_o (empty_v[g]),
      .head_o  (head_v[g])
    );
  end

  // Fetch/distribute FSM; a start during REQ lets the pending read finish and drops it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      rd_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      discard_q <= 1'b0;
      addr_q    <= CHART_BASE;
      word_q    <= '0;
      idx_q     <= '0;
      wcnt_q    <= '0;
    end else begin
      done_q <= !start && (state_q == S_END) && (&empty_v);
      case (state_q)
        S_IDLE, S_END: begin
          if (start) begin
            state_q   <= S_REQ;
            rd_q      <= 1'b1;
            busy_q    <= 1'b1;
            addr_q    <= CHART_BASE;
            wcnt_q    <= '0;
            discard_q <= 1'b0;
          end
        end
        S_REQ: begin
          if (sdram_ac) begin
            if (discard_q || start) begin
              addr_q    <= CHART_BASE;
              wcnt_q    <= '0;
              discard_q <= 1'b0;
            end else begin
              state_q <= S_DIST;
              rd_q    <= 1'b0;
              word_q  <= sdram_data;
              addr_q  <= addr_q + 22'd1;
              wcnt_q  <= wcnt_q + WCNT_W'(1);
              idx_q   <= '0;
            end
          end else if (start) begin
            discard_q <= 1'b1;
          end
        end
        S_DIST: begin
          if (start) begin
            state_q <= S_REQ;
            rd_q    <= 1'b1;
            addr_q  <= CHART_BASE;
            wcnt_q  <= '0;
          end else if (is_sent_c) begin
            state_q <= S_END;
            busy_q  <= 1'b0;
          end else if (!full_v[entry_c.lane]) begin
            if (idx_q == 3'(ENTRIES - 1)) begin
              if (wcnt_q == WCNT_W'(MAX_WORDS)) begin
                state_q <= S_END;
                busy_q  <= 1'b0;
              end else begin
                state_q <= S_REQ;
                rd_q    <= 1'b1;
              end
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign delta_c = $signed({1'b0, time_q}) - $signed({3'b000, head_v[jlane_q]});
  assign mag_c   = abs_delta(delta_c);

  always_comb begin
    grade_c = GRADE_NONE;
    if (sweep_q && !start && !empty_v[jlane_q]) begin
      if (press_q[jlane_q]) begin
        if (mag_c <= DELTA_W'(PERFECT_WIN))   grade_c = GRADE_PERFECT;
        else if (mag_c <= DELTA_W'(GOOD_WIN)) grade_c = GRADE_GOOD;
      end else if (!delta_c[DELTA_W-1] && mag_c > DELTA_W'(GOOD_WIN)) begin
        grade_c = GRADE_MISS;
      end
    end
  end

  always_comb begin
    sum_c = {1'b0, score_q};
    if (grade_c == GRADE_PERFECT)   sum_c = {1'b0, score_q} + (SCORE_W+1)'(PTS_PERFECT);
    else if (grade_c == GRADE_GOOD) sum_c = {1'b0, score_q} + (SCORE_W+1)'(PTS_GOOD);
    score_d = sum_c[SCORE_W] ? '1 : sum_c[SCORE_W-1:0];
    combo_d = combo_q;
    if (grade_c == GRADE_MISS) combo_d = '0;
    else if (grade_c != GRADE_NONE && combo_q != '1) combo_d = combo_q + COMBO_W'(1);
  end

  // Judge sequencer: one lane per cycle for four cycles after each frame strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sweep_q     <= 1'b0;
      jlane_q     <= '0;
      press_q     <= '0;
      dfjk_prev_q <= '0;
      time_q      <= '0;
      valid_q     <= 1'b0;
      lane_out_q  <= '0;
      grade_q     <= GRADE_NONE;
      score_q     <= '0;
      combo_q     <= '0;
    end else begin
      valid_q <= 1'b0;
      if (start) begin
        sweep_q <= 1'b0;
        score_q <= '0;
        combo_q <= '0;
      end else if (sweep_q) begin
        if (grade_c != GRADE_NONE) begin
          valid_q    <= 1'b1;
          lane_out_q <= jlane_q;
          grade_q    <= grade_c;
          score_q    <= score_d;
          combo_q    <= combo_d;
        end
        jlane_q <= jlane_q + LANE_W'(1);
        if (jlane_q == LANE_W'(NUM_LANES - 1)) sweep_q <= 1'b0;
      end else if (new_frame) begin
        press_q     <= DFJK & ~dfjk_prev_q;
        dfjk_prev_q <= DFJK;
        time_q      <= un_time;
        sweep_q     <= 1'b1;
        jlane_q     <= '0;
      end
    end
  end

endmodule
